// File: rtl/paddle_ctrl_if.sv
// Keycode in / paddle positions and serve out, bundled for the paddle controller.
interface paddle_ctrl_if;
    logic        frame_clk;
    logic [31:0] keycode;
    logic [9:0]  paddle_l_y;
    logic [9:0]  paddle_r_y;
    logic        serve;

    modport master (
        output frame_clk, keycode,
        input  paddle_l_y, paddle_r_y, serve
    );

    modport slave (
        input  frame_clk, keycode,
        output paddle_l_y, paddle_r_y, serve
    );
endinterface

// File: rtl/paddle_ctrl.sv
// Per-frame paddle motion: keycode decode, hold-to-accelerate stepping with
// edge clamping for two independent paddles, and a one-shot serve pulse.

// One paddle: IDLE/UP/DOWN FSM plus step/acc accelerator and clamped y.
module paddle_axis #(
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 479,
    parameter int PADDLE_H     = 64,
    parameter int START_Y      = 208,
    parameter int MAX_STEP     = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       tick,
    input  logic       up_key,
    input  logic       dn_key,
    output logic [9:0] y
);
    localparam int SW = $clog2(MAX_STEP + 1);
    localparam int AW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [10:0]   Y_TOP    = 11'(Y_MIN);
    localparam logic [10:0]   Y_BOT    = 11'(Y_MAX + 1 - PADDLE_H);
    localparam logic [SW-1:0] STEP_MAX = SW'(MAX_STEP);
    localparam logic [AW-1:0] ACC_LAST = AW'(ACCEL_FRAMES - 1);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t        state_q, state_d, cmd;
    logic [SW-1:0] step_q, step_d, mv;
    logic [AW-1:0] acc_q, acc_d;
    logic [9:0]    y_q, y_d;
    logic [10:0]   y_ext, mv_ext;

    // Decode this frame's command; both keys together cancel out.
    always_comb begin
        cmd = IDLE;
        if (up_key && !dn_key)      cmd = UP;
        else if (dn_key && !up_key) cmd = DOWN;
    end

    // State register for FSM, accelerator and position.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            step_q  <= SW'(1);
            acc_q   <= '0;
            y_q     <= 10'(START_Y);
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
        end
    end

    // Next state: follow the command, but only on frame ticks.
    always_comb begin
        state_d = state_q;
        if (tick) state_d = cmd;
    end

    // Step/acc update and clamped move. A direction change restarts at step 1
    // and acc 0, so the change frame itself is not counted toward acceleration.
    always_comb begin
        step_d = step_q;
        acc_d  = acc_q;
        y_d    = y_q;
        mv     = step_q;
        y_ext  = {1'b0, y_q};
        mv_ext = 11'(step_q);
        if (tick) begin
            if (cmd != state_q) begin
                step_d = SW'(1);
                acc_d  = '0;
                mv     = SW'(1);
            end else if (state_q != IDLE) begin
                if (acc_q == ACC_LAST) begin
                    acc_d = '0;
                    if (step_q < STEP_MAX) step_d = step_q + 1'b1;
                end else begin
                    acc_d = acc_q + 1'b1;
                end
            end
            mv_ext = 11'(mv);
            case (cmd)
                UP:      y_d = (y_ext < Y_TOP + mv_ext) ? Y_TOP[9:0] : 10'(y_ext - mv_ext);
                DOWN:    y_d = (y_ext + mv_ext > Y_BOT) ? Y_BOT[9:0] : 10'(y_ext + mv_ext);
                default: y_d = y_q;
            endcase
        end
    end

    assign y = y_q;
endmodule

// Top: frame tick edge detect, key decode, two paddle lanes, serve one-shot.
module paddle_ctrl #(
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 479,
    parameter int PADDLE_H     = 64,
    parameter int START_Y      = 208,
    parameter int MAX_STEP     = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    paddle_ctrl_if.slave  bus
);
    localparam int NUM_LANES = 2;  // lane 0 = left, lane 1 = right
    localparam logic [NUM_LANES-1:0][7:0] UP_CODE = {8'h52, 8'h1A};
    localparam logic [NUM_LANES-1:0][7:0] DN_CODE = {8'h51, 8'h16};
    localparam logic [7:0]                SPACE   = 8'h2C;

    function automatic logic key_hit(input logic [31:0] kc, input logic [7:0] code);
        logic hit;
        hit = 1'b0;
        for (int b = 0; b < 4; b++) hit = hit | (kc[8*b +: 8] == code);
        return hit;
    endfunction

    logic frame_d_q, frame_d_d;
    logic space_prev_q, space_prev_d;
    logic serve_q, serve_d;
    logic tick, space;
    logic [NUM_LANES-1:0][9:0] y_lane;

    assign tick  = bus.frame_clk & ~frame_d_q;
    assign space = key_hit(bus.keycode, SPACE);

    // Tick detect, Space history and registered serve pulse.
    always_comb begin
        frame_d_d    = bus.frame_clk;
        space_prev_d = tick ? space : space_prev_q;
        serve_d      = tick & space & ~space_prev_q;
    end

    // Top-level flops.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_d_q    <= 1'b0;
            space_prev_q <= 1'b0;
            serve_q      <= 1'b0;
        end else begin
            frame_d_q    <= frame_d_d;
            space_prev_q <= space_prev_d;
            serve_q      <= serve_d;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        paddle_axis #(
            .Y_MIN(Y_MIN), .Y_MAX(Y_MAX), .PADDLE_H(PADDLE_H), .START_Y(START_Y),
            .MAX_STEP(MAX_STEP), .ACCEL_FRAMES(ACCEL_FRAMES)
        ) u_axis (
            .Clk    (Clk),
            .Reset  (Reset),
            .tick   (tick),
            .up_key (key_hit(bus.keycode, UP_CODE[g])),
            .dn_key (key_hit(bus.keycode, DN_CODE[g])),
            .y      (y_lane[g])
        );
    end

    assign bus.paddle_l_y = y_lane[0];
    assign bus.paddle_r_y = y_lane[1];
    assign bus.serve      = serve_q;
endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: vector table through a scoreboard queue, plus
// hand sequences for clamping, async reset mid-motion and tick-at-release.
module tb_paddle_ctrl;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    paddle_ctrl_if bus();
    paddle_ctrl dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    typedef struct {logic [31:0] kc; logic [9:0] l; logic [9:0] r; logic s;} vec_t;
    typedef struct {logic [9:0] l; logic [9:0] r; logic s;} exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int l, input int r, input logic s);
        exp_t e;
        e.l = 10'(l);
        e.r = 10'(r);
        e.s = s;
        return e;
    endfunction

    task automatic add(input logic [31:0] kc, input int l, input int r, input logic s);
        vec_t v;
        v.kc = kc;
        v.l  = 10'(l);
        v.r  = 10'(r);
        v.s  = s;
        vecs.push_back(v);
    endtask

    // One frame: rising frame_clk with kc, junk keycode between ticks.
    task automatic do_tick(input logic [31:0] kc, input exp_t e);
        exp_t got;
        @(negedge Clk);
        bus.keycode   = kc;
        bus.frame_clk = 1'b1;
        exp_q.push_back(e);
        @(posedge Clk); #1;
        got = exp_q.pop_front();
        check("l_y", {22'd0, bus.paddle_l_y}, {22'd0, got.l});
        check("r_y", {22'd0, bus.paddle_r_y}, {22'd0, got.r});
        check("serve", {31'd0, bus.serve}, {31'd0, got.s});
        @(negedge Clk);
        bus.keycode = $urandom;
        @(posedge Clk); #1;
        check("serve_width", {31'd0, bus.serve}, 32'd0);
        check("l_hold", {22'd0, bus.paddle_l_y}, {22'd0, got.l});
        check("r_hold", {22'd0, bus.paddle_r_y}, {22'd0, got.r});
        @(negedge Clk);
        bus.frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int wseq[20];
        int rseq[14];
        logic [31:0] wkc[4];
        int my, ms, ma;

        wseq = '{207, 206, 205, 204, 203, 201, 199, 197, 195, 192,
                 189, 186, 183, 179, 175, 171, 167, 162, 157, 152};
        rseq = '{211, 212, 213, 214, 215, 217, 219, 221, 223, 226, 229, 232, 235, 239};
        wkc  = '{32'h0000001A, 32'h00041A00, 32'h001A0000, 32'h1A050000};

        bus.frame_clk = 1'b0;
        bus.keycode   = 32'h0;
        Reset         = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_l", {22'd0, bus.paddle_l_y}, 32'd208);
        check("rst_r", {22'd0, bus.paddle_r_y}, 32'd208);
        check("rst_serve", {31'd0, bus.serve}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("idle_l", {22'd0, bus.paddle_l_y}, 32'd208);

        // Vector table
        repeat (3) add(32'h0, 208, 208, 1'b0);
        for (int i = 0; i < 20; i++) add(wkc[i % 4], wseq[i], 208, 1'b0);
        add(32'h00000016, 153, 208, 1'b0);   // reversal: +1
        add(32'h0000161A, 153, 208, 1'b0);   // both keys: no move
        add(32'h1A000016, 153, 208, 1'b0);
        add(32'h00510000, 153, 209, 1'b0);
        add(32'h51000000, 153, 210, 1'b0);
        add(32'h00005251, 153, 210, 1'b0);
        add(32'h2C000000, 153, 210, 1'b1);   // new Space
        repeat (4) add(32'h2C000000, 153, 210, 1'b0);
        add(32'h00000000, 153, 210, 1'b0);
        add(32'h002C0000, 153, 210, 1'b1);   // pressed again
        add(32'h2C2C0000, 153, 210, 1'b0);
        add(32'h2C1A0000, 152, 210, 1'b0);   // held Space + W start

        for (int i = 0; i < vecs.size(); i++)
            do_tick(vecs[i].kc, mk(int'(vecs[i].l), int'(vecs[i].r), vecs[i].s));

        // Down clamp: 100 frames of S from 152 while in UP
        my = 153; ms = 1; ma = 0;
        do_tick(32'h00001600, mk(my, 210, 1'b0));
        for (int i = 1; i < 100; i++) begin
            my = (my + ms > 416) ? 416 : my + ms;
            if (ma == 3) begin
                ma = 0;
                ms = (ms < 8) ? ms + 1 : 8;
            end else begin
                ma = ma + 1;
            end
            do_tick(32'h00001600, mk(my, 210, 1'b0));
        end
        check("clamp_final", {22'd0, bus.paddle_l_y}, 32'd416);

        // Right DOWN up to step 4, then async reset between ticks
        for (int i = 0; i < 14; i++) do_tick(32'h00000051, mk(416, rseq[i], 1'b0));
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("async_r", {22'd0, bus.paddle_r_y}, 32'd208);
        check("async_l", {22'd0, bus.paddle_l_y}, 32'd208);
        @(negedge Clk);
        Reset = 1'b0;
        do_tick(32'h00000051, mk(208, 209, 1'b0));

        // frame_clk already high when reset releases: tick on first cycle
        @(negedge Clk);
        Reset         = 1'b1;
        bus.frame_clk = 1'b1;
        bus.keycode   = 32'h2C00001A;
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk); #1;
        check("rel_tick_l", {22'd0, bus.paddle_l_y}, 32'd207);
        check("rel_tick_r", {22'd0, bus.paddle_r_y}, 32'd208);
        check("rel_tick_serve", {31'd0, bus.serve}, 32'd1);
        @(posedge Clk); #1;
        check("rel_no_retick", {22'd0, bus.paddle_l_y}, 32'd207);
        @(negedge Clk);
        bus.frame_clk = 1'b0;

        check("sb_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
